// File: rtl/encoder4to2_reg_pkg.sv
// Shared encoder helpers: index-width rule, highest-set-bit index and popcount.
// Vectors are handled at a fixed maximum width so that 4-to-2, 8-to-3 and
// round-robin encoders can share one set of functions; callers zero-extend.
package enc_pkg;

  localparam int unsigned MAX_W = 32;

  typedef logic [MAX_W-1:0] vec_t;

  // Output index width for a WIDTH-bit request vector.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic int unsigned prio_idx(input vec_t v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int unsigned popcount(input vec_t v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/encoder4to2_reg_if.sv
// Handshake bus of the registered encoder.
//   in_valid/in_ready/in          : upstream request vector
//   out_valid/out_ready/out/any/multi : downstream registered result
// master: the side driving requests and consuming results; slave: the encoder.
interface encoder4to2_reg_if
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IDX_W = idx_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out;
  logic             any;
  logic             multi;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, any, multi
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, any, multi
  );

endinterface

// File: rtl/encoder4to2_reg_prio_enc_comb.sv
// Pure combinational priority encoder.
//   i_vec   : request vector
//   o_idx   : index of highest set bit (0 when i_vec is zero)
//   o_any   : i_vec non-zero
//   o_multi : two or more bits of i_vec set
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]           i_vec,
  output logic [idx_width(WIDTH)-1:0] o_idx,
  output logic                       o_any,
  output logic                       o_multi
);
  localparam int unsigned IDX_W = idx_width(WIDTH);

  vec_t w_vec;

  always_comb begin
    w_vec              = '0;
    w_vec[WIDTH-1:0]   = i_vec;
    o_idx              = IDX_W'(prio_idx(w_vec));
    o_any              = |i_vec;
    o_multi            = (popcount(w_vec) >= 2);
  end

endmodule

// File: rtl/encoder4to2_reg.sv
// Registered priority encoder with valid/ready on both sides.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   en         : 0 blocks new captures; a pending result still drains
//   bus        : slave side of encoder4to2_reg_if (request in, index/any/multi out)
//   err_cnt    : saturating count of accepted multi-hot vectors
module encoder4to2_reg
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  encoder4to2_reg_if.slave     bus,
  output logic [ERR_W-1:0]     err_cnt
);
  localparam int unsigned IDX_W = idx_width(WIDTH);

  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;
  logic             w_accept;

  logic             r_out_valid;
  logic [IDX_W-1:0] r_out;
  logic             r_any;
  logic             r_multi;
  logic [ERR_W-1:0] r_err_cnt;

  prio_enc_comb #(.WIDTH(WIDTH)) u_prio (
    .i_vec   (bus.in),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  // Slot frees up in the same cycle it drains, so back-to-back transfers
  // run without a bubble.
  assign bus.in_ready = en & (~r_out_valid | bus.out_ready);
  assign w_accept     = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_any       <= 1'b0;
      r_multi     <= 1'b0;
      r_err_cnt   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out       <= w_idx;
      r_any       <= w_any;
      r_multi     <= w_multi;
      if (w_multi && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end else if (bus.out_ready) begin
      // Result consumed with nothing new: drop valid, keep last data visible.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.any       = r_any;
  assign bus.multi     = r_multi;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_encoder4to2_reg.sv
// Directed bench for encoder4to2_reg (WIDTH=4, ERR_W=2 so saturation is reachable).
module tb_encoder4to2_reg;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] err_cnt;

  int unsigned n_checks;
  int unsigned n_err;

  encoder4to2_reg_if #(.WIDTH(4)) bus ();

  encoder4to2_reg #(.WIDTH(4), .ERR_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dec2to4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] o,
                           input logic a, input logic m, input logic [1:0] e);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".out"},   32'(bus.out),       32'(o));
    check({tag, ".any"},   32'(bus.any),       32'(a));
    check({tag, ".multi"}, 32'(bus.multi),     32'(m));
    check({tag, ".err"},   32'(err_cnt),       32'(e));
  endtask

  logic [3:0] onehot [4];
  logic [3:0] mh_vec [5];
  logic [1:0] mh_idx [5];
  logic [1:0] mh_err [5];

  initial begin
    n_checks = 0;
    n_err    = 0;
    onehot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mh_vec = '{4'b1111, 4'b0011, 4'b1100, 4'b0110, 4'b0101};
    mh_idx = '{2'd3, 2'd1, 2'd3, 2'd2, 2'd2};
    mh_err = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    rst_n         = 1'b0;
    en            = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = 4'b0000;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One-hot sweep with loopback through a 2-to-4 decode.
    en            = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in = onehot[i];
      @(negedge clk);
      check_out("onehot", 1'b1, 2'(i), 1'b1, 1'b0, 2'd0);
      check("loopback", 32'(dec2to4(bus.out)), 32'(onehot[i]));
    end

    // Priority with multi-hot, then zero vector.
    bus.in = 4'b1010;
    @(negedge clk);
    check_out("prio1010", 1'b1, 2'd3, 1'b1, 1'b1, 2'd1);
    bus.in = 4'b0000;
    @(negedge clk);
    check_out("zero", 1'b1, 2'd0, 1'b0, 1'b0, 2'd1);

    // Backpressure.
    bus.in = 4'b0100;
    @(negedge clk);
    check_out("bp_load", 1'b1, 2'd2, 1'b1, 1'b0, 2'd1);
    bus.in        = 4'b0001;
    bus.out_ready = 1'b0;
    #1;
    check("bp_in_ready_lo", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_out("bp_hold1", 1'b1, 2'd2, 1'b1, 1'b0, 2'd1);
    @(negedge clk);
    check_out("bp_hold2", 1'b1, 2'd2, 1'b1, 1'b0, 2'd1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_hi", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_out("bp_release", 1'b1, 2'd0, 1'b1, 1'b0, 2'd1);

    // Enable low: no capture, pending result drains.
    en            = 1'b0;
    bus.in        = 4'b1000;
    bus.out_ready = 1'b0;
    #1;
    check("en0_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_out("en0_hold", 1'b1, 2'd0, 1'b1, 1'b0, 2'd1);
    bus.out_ready = 1'b1;
    #1;
    check("en0_in_ready_drain", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_out("en0_drain", 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("idle", 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);

    // Saturating error counter.
    en           = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in = mh_vec[i];
      @(negedge clk);
      check_out("sat", 1'b1, mh_idx[i], 1'b1, 1'b1, mh_err[i]);
    end

    // Asynchronous reset mid-transfer with a result pending.
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_out("post_rst", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
